// File: rtl/mem_access_seq_if.sv
// Request/response and memory-side signals of the memory access sequencer.
// slave is the sequencer's view; master is the requester plus memory.
interface mem_access_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [11:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_data;
   logic        resp_err;
   logic [11:0] mem_address;
   logic [15:0] mem_data_out;
   logic        mem_write_en;
   logic [15:0] mem_result;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_result,
      output req_ready, resp_valid, resp_data, resp_err,
      output mem_address, mem_data_out, mem_write_en
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_result,
      input  req_ready, resp_valid, resp_data, resp_err,
      input  mem_address, mem_data_out, mem_write_en
   );
endinterface

// File: rtl/mem_access_seq.sv
// Single-request memory sequencer: read / write / increment / add-to-memory
// with AGC edit registers (020-023) and write protection of fixed memory.
module mem_access_seq #(
   parameter int unsigned READ_LAT  = 1,
   parameter int unsigned ONES_COMP = 1
) (
   input logic            clk,
   input logic            rst,
   mem_access_seq_if.slave bus
);
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_MODIFY, S_WRITE, S_RESP} state_e;
   typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INCR, OP_ADS} op_e;

   state_e        state_q, state_d;
   op_e           op_q, op_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d;
   logic          resp_valid_q, resp_valid_d;
   logic [DW-1:0] resp_data_q, resp_data_d;
   logic          resp_err_q, resp_err_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_data_q, mem_data_d;
   logic          mem_we_q, mem_we_d;
   logic          fixed_c;
   logic [DW-1:0] sum_c;
   logic [DW-1:0] edit_c;

   function automatic logic [DW-1:0] add16(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (ONES_COMP != 0) return s[DW-1:0] + DW'(s[DW]);
      return s[DW-1:0];
   endfunction

   // Edit registers reshape whatever is stored into them.
   function automatic logic [DW-1:0] edit(input logic [AW-1:0] a, input logic [DW-1:0] d);
      case (a)
         12'o20:  return {d[0], d[15:1]};
         12'o21:  return {d[15], d[15:1]};
         12'o22:  return {d[14:0], d[15]};
         12'o23:  return d >> 7;
         default: return d;
      endcase
   endfunction

   assign fixed_c = (addr_q >= 12'o2000);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      cnt_d        = cnt_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_we_d     = 1'b0;
      sum_c        = add16(rdata_q, (op_q == OP_INCR) ? DW'(1) : wdata_q);
      edit_c       = edit(addr_q, (op_q == OP_WRITE) ? wdata_q : sum_c);

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               op_d        = op_e'(bus.req_op);
               addr_d      = bus.req_addr;
               wdata_d     = bus.req_wdata;
               req_ready_d = 1'b0;
               state_d     = S_ADDR;
            end
         end
         S_ADDR: begin
            mem_addr_d = addr_q;
            if (op_q == OP_WRITE) begin
               wdata_d = edit_c;
               if (!fixed_c) begin
                  mem_we_d   = 1'b1;
                  mem_data_d = edit_c;
               end
               state_d = S_WRITE;
            end else begin
               cnt_d   = CW'(READ_LAT - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = bus.mem_result;
               if (op_q == OP_READ) begin
                  resp_valid_d = 1'b1;
                  resp_data_d  = bus.mem_result;
                  resp_err_d   = 1'b0;
                  state_d      = S_RESP;
               end else begin
                  state_d = S_MODIFY;
               end
            end else begin
               cnt_d = CW'(cnt_q - 1'b1);
            end
         end
         S_MODIFY: begin
            wdata_d = edit_c;
            if (!fixed_c) begin
               mem_we_d   = 1'b1;
               mem_data_d = edit_c;
            end
            state_d = S_WRITE;
         end
         S_WRITE: begin
            resp_valid_d = 1'b1;
            resp_err_d   = fixed_c;
            if (!fixed_c)              resp_data_d = wdata_q;
            else if (op_q == OP_WRITE) resp_data_d = '0;
            else                       resp_data_d = rdata_q;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: begin
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_READ;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_we_q     <= mem_we_d;
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_data    = resp_data_q;
   assign bus.resp_err     = resp_err_q;
   assign bus.mem_address  = mem_addr_q;
   assign bus.mem_data_out = mem_data_q;
   assign bus.mem_write_en = mem_we_q;
endmodule
